// File: rtl/nios2_dct_pkg.sv
// Shared constants, state type and atom-placement helper for the Nios II DCT packer.
package nios2_dct_pkg;

   localparam int unsigned ATOM_W = 2;
   localparam int unsigned ATOMS  = 15;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned BUF_W  = ATOM_W * ATOMS;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ATOMS);

   typedef enum logic [1:0] {StRun, StDrain, StDone} dct_state_e;

   // Writes atom into slot idx of acc, LSB first; other slots are untouched.
   function automatic logic [BUF_W-1:0] place_atom(input logic [BUF_W-1:0]  acc,
                                                    input logic [CNT_W-1:0]  idx,
                                                    input logic [ATOM_W-1:0] atom);
      logic [BUF_W-1:0] res;
      res = acc;
      for (int unsigned k = 0; k < ATOMS; k++) begin
         if (CNT_W'(k) == idx) begin
            res[k*ATOM_W +: ATOM_W] = atom;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/nios2_dct_out_slot.sv
// Single-entry output register for DCT frames; holds data stable until the writer accepts it.
module nios2_dct_out_slot
   import nios2_dct_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [BUF_W-1:0] load_buffer,
   input  logic [CNT_W-1:0] load_count,
   input  logic             ready,
   output logic             valid,
   output logic [BUF_W-1:0] buffer,
   output logic [CNT_W-1:0] count,
   output logic             free
);

   logic             valid_q, valid_d;
   logic [BUF_W-1:0] buffer_q, buffer_d;
   logic [CNT_W-1:0] count_q, count_d;

   // A frame accepted this cycle frees the slot for a back-to-back load.
   assign free = !valid_q || ready;

   always_comb begin
      valid_d  = valid_q;
      buffer_d = buffer_q;
      count_d  = count_q;
      if (load) begin
         valid_d  = 1'b1;
         buffer_d = load_buffer;
         count_d  = load_count;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q  <= 1'b0;
         buffer_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         buffer_q <= buffer_d;
         count_q  <= count_d;
      end
   end

   assign valid  = valid_q;
   assign buffer = buffer_q;
   assign count  = count_q;

endmodule

// File: rtl/nios2_dct_pack_ctrl.sv
// Packs 2-bit trace atoms into 30-bit DCT frames and runs the end-of-test drain.
// Optional NIOS2_DCT_DROP_CNT_EN adds a saturating drop_count output.
module nios2_dct_pack_ctrl
   import nios2_dct_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              atom_valid,
   input  logic [ATOM_W-1:0] atom_data,
   input  logic              test_ending,
   output logic              frame_valid,
   output logic [BUF_W-1:0]  frame_buffer,
   output logic [CNT_W-1:0]  frame_count,
   input  logic              frame_ready,
   output logic              overflow,
   output logic              test_has_ended
`ifdef NIOS2_DCT_DROP_CNT_EN
   ,
   output logic [7:0]        drop_count
`endif
);

   dct_state_e       state_q, state_d;
   logic [BUF_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             slot_free;
   logic             acc_full;
   logic             transfer;

   assign acc_full = (cnt_q == FULL_CNT);
   assign transfer = slot_free && (acc_full || (state_q == StDrain && cnt_q != '0));

   nios2_dct_out_slot u_out_slot (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (transfer),
      .load_buffer (acc_q),
      .load_count  (cnt_q),
      .ready       (frame_ready),
      .valid       (frame_valid),
      .buffer      (frame_buffer),
      .count       (frame_count),
      .free        (slot_free)
   );

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      ovf_d   = ovf_q;
      if (transfer) begin
         acc_d = '0;
         cnt_d = '0;
      end
      unique case (state_q)
         StRun: begin
            if (atom_valid) begin
               if (transfer) begin
                  // Accumulator is handed off this cycle, so the atom starts the next frame.
                  acc_d = place_atom('0, '0, atom_data);
                  cnt_d = CNT_W'(1);
               end else if (!acc_full) begin
                  acc_d = place_atom(acc_q, cnt_q, atom_data);
                  cnt_d = cnt_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (test_ending) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (cnt_q == '0 && !frame_valid) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StRun;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign overflow       = ovf_q;
   assign test_has_ended = (state_q == StDone);

`ifdef NIOS2_DCT_DROP_CNT_EN
   logic [7:0] drop_q;
   logic       drop_evt;

   assign drop_evt = (state_q == StRun) && atom_valid && acc_full && !transfer;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_q <= 8'd0;
      end else if (drop_evt && drop_q != 8'hFF) begin
         drop_q <= drop_q + 8'd1;
      end
   end

   assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_nios2_dct_pack_ctrl.sv
// Bench for nios2_dct_pack_ctrl: directed and random atom streams against a queue-based model.
module tb_nios2_dct_pack_ctrl;

   logic        clk;
   logic        reset_n;
   logic        atom_valid;
   logic [1:0]  atom_data;
   logic        test_ending;
   logic        frame_valid;
   logic [29:0] frame_buffer;
   logic [3:0]  frame_count;
   logic        frame_ready;
   logic        overflow;
   logic        test_has_ended;
`ifdef NIOS2_DCT_DROP_CNT_EN
   logic [7:0]  drop_count;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: atoms as queues, mode as two flags.
   logic [1:0] m_acc[$];
   logic [1:0] m_pend[$];
   bit         m_fv;
   bit         m_drain;
   bit         m_ended;
   bit         m_ovf;
   int         m_drops;

   nios2_dct_pack_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .atom_valid     (atom_valid),
      .atom_data      (atom_data),
      .test_ending    (test_ending),
      .frame_valid    (frame_valid),
      .frame_buffer   (frame_buffer),
      .frame_count    (frame_count),
      .frame_ready    (frame_ready),
      .overflow       (overflow),
      .test_has_ended (test_has_ended)
`ifdef NIOS2_DCT_DROP_CNT_EN
      ,
      .drop_count     (drop_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [29:0] pack(input logic [1:0] q[$]);
      logic [29:0] r;
      r = '0;
      for (int k = 0; k < q.size(); k++) begin
         r = r | (30'(q[k]) << (2 * k));
      end
      return r;
   endfunction

   task automatic model_clear();
      m_acc   = {};
      m_pend  = {};
      m_fv    = 0;
      m_drain = 0;
      m_ended = 0;
      m_ovf   = 0;
      m_drops = 0;
   endtask

   task automatic model_update(input bit av, input logic [1:0] a, input bit te, input bit rdy);
      bit free;
      bit xfer;
      bit old_fv;
      int old_size;
      old_fv   = m_fv;
      old_size = m_acc.size();
      free     = !m_fv || rdy;
      xfer     = free && (old_size == 15 || (m_drain && !m_ended && old_size > 0));
      if (xfer) begin
         m_pend = m_acc;
         m_fv   = 1;
         m_acc  = {};
      end else if (m_fv && rdy) begin
         m_fv = 0;
      end
      if (!m_drain && !m_ended && av) begin
         if (m_acc.size() < 15) begin
            m_acc.push_back(a);
         end else begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
         end
      end
      if (m_drain && !m_ended) begin
         if (old_size == 0 && !old_fv) m_ended = 1;
      end else if (!m_drain && te) begin
         m_drain = 1;
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, "_valid"}, 32'(frame_valid), 32'(m_fv));
      if (m_fv) begin
         chk({tag, "_buffer"}, 32'(frame_buffer), 32'(pack(m_pend)));
         chk({tag, "_count"}, 32'(frame_count), 32'(m_pend.size()));
      end
      chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, "_ended"}, 32'(test_has_ended), 32'(m_ended));
`ifdef NIOS2_DCT_DROP_CNT_EN
      chk({tag, "_drops"}, 32'(drop_count), 32'(m_drops));
`endif
   endtask

   task automatic step(input string tag, input bit av, input logic [1:0] a, input bit te,
                       input bit rdy);
      atom_valid  = av;
      atom_data   = a;
      test_ending = te;
      frame_ready = rdy;
      @(posedge clk);
      model_update(av, a, te, rdy);
      #1;
      compare_all(tag);
   endtask

   // Asserts reset away from a clock edge and checks outputs clear without a clock.
   task automatic do_reset();
      atom_valid  = 0;
      atom_data   = 0;
      test_ending = 0;
      frame_ready = 0;
      reset_n     = 0;
      #1;
      model_clear();
      chk("rst_valid", 32'(frame_valid), 32'd0);
      chk("rst_buffer", 32'(frame_buffer), 32'd0);
      chk("rst_count", 32'(frame_count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_ended", 32'(test_has_ended), 32'd0);
      @(negedge clk);
      reset_n = 1;
   endtask

   initial begin
      reset_n     = 1;
      atom_valid  = 0;
      atom_data   = 0;
      test_ending = 0;
      frame_ready = 0;
      #2;

      // Full frame of 2'b01, ready high.
      do_reset();
      for (int i = 0; i < 15; i++) step("t1", 1, 2'b01, 0, 1);
      chk("t1_not_yet", 32'(frame_valid), 32'd0);
      step("t1", 0, 2'b00, 0, 1);
      chk("t1_fv", 32'(frame_valid), 32'd1);
      chk("t1_buf", 32'(frame_buffer), 32'h15555555);
      chk("t1_cnt", 32'(frame_count), 32'd15);
      step("t1", 0, 2'b00, 0, 1);
      chk("t1_ovf", 32'(overflow), 32'd0);

      // 30 atoms 0,1,2,3,... back to back.
      do_reset();
      for (int i = 0; i < 30; i++) step("t2", 1, 2'(i % 4), 0, 1);
      for (int i = 0; i < 4; i++) step("t2", 0, 2'b00, 0, 1);

      // Writer stalled: second frame fills, 31st atom is dropped.
      do_reset();
      for (int i = 0; i < 31; i++) step("t3", 1, 2'($urandom_range(0, 3)), 0, 0);
      chk("t3_ovf", 32'(overflow), 32'd1);
      for (int i = 0; i < 3; i++) step("t3", 0, 2'b00, 0, 1);

      // Partial frame flushed by drain.
      do_reset();
      for (int i = 0; i < 5; i++) step("t4", 1, 2'b11, 0, 1);
      step("t4", 0, 2'b00, 1, 1);
      step("t4", 0, 2'b00, 1, 0);
      chk("t4_buf", 32'(frame_buffer), 32'h000003FF);
      chk("t4_cnt", 32'(frame_count), 32'd5);
      for (int i = 0; i < 4; i++) step("t4", 0, 2'b00, 1, 1);
      chk("t4_ended", 32'(test_has_ended), 32'd1);
      for (int i = 0; i < 20; i++) step("t4_done", 1, 2'b10, 0, 1);

      // Drain with nothing pending.
      do_reset();
      step("t5", 0, 2'b00, 1, 1);
      step("t5", 0, 2'b00, 0, 1);
      chk("t5_ended", 32'(test_has_ended), 32'd1);
      chk("t5_nofv", 32'(frame_valid), 32'd0);

      // Reset with a pending frame and 7 accumulated atoms.
      do_reset();
      for (int i = 0; i < 15; i++) step("t6", 1, 2'b10, 0, 0);
      step("t6", 0, 2'b00, 0, 0);
      for (int i = 0; i < 7; i++) step("t6", 1, 2'b01, 0, 0);
      do_reset();
      for (int i = 0; i < 15; i++) step("t6_post", 1, 2'b11, 0, 1);
      step("t6_post", 0, 2'b00, 0, 0);
      chk("t6_buf", 32'(frame_buffer), 32'h3FFFFFFF);

      // Random streams with random writer stalls, then drain.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int i = 0; i < 80; i++) begin
            step("rnd", bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 bit'(i >= 70), bit'($urandom_range(0, 2 + r) == 0));
         end
         for (int i = 0; i < 100; i++) begin
            if (m_ended) break;
            step("rnd_drain", bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0));
         end
         chk("rnd_ended", 32'(test_has_ended), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
